// File: rtl/uart_rx_frame_if.sv
// Word handshake from the UART receiver to its consumer: data, line-error
// flags and the overrun pulse travel together with valid/ready.
interface uart_rx_frame_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 brk;
  logic                 overrun;

  modport master (output rx_data, rx_valid, parity_err, frame_err, brk, overrun,
                  input  rx_ready);
  modport slave  (input  rx_data, rx_valid, parity_err, frame_err, brk, overrun,
                  output rx_ready);
endinterface

// File: rtl/uart_rx_frame.sv
// Parametrised RS-232 receiver with parity, line-error flags and valid/ready output.
// Define UART_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH FIFO.
module uart_rx_frame #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rxd_i,
  output logic            rx_busy_o,
  uart_rx_frame_if.master rx_o
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [31:0] INC = 32'(BAUD * OVERSAMPLE);
  localparam logic [31:0] MOD = 32'(CLK_FREQ);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRKWAIT} state_t;
  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 pe;
    logic                 fe;
    logic                 bk;
  } ent_t;

  // Fractional phase accumulator: adds BAUD*OVERSAMPLE per clk, wraps at CLK_FREQ
  logic [31:0] acc_q, acc_d;
  logic        tick;

  always_comb begin
    acc_d = acc_q + INC;
    tick  = (acc_d >= MOD);
    if (tick) acc_d = acc_d - MOD;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  logic [1:0] sync_q;
  logic [1:0] samp_q;
  logic       line_f_q;
  logic       maj;

  assign maj = (samp_q[1] & samp_q[0]) | (samp_q[1] & sync_q[1]) | (samp_q[0] & sync_q[1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      samp_q   <= 2'b11;
      line_f_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rxd_i};
      if (tick) begin
        samp_q   <= {samp_q[0], sync_q[1]};
        line_f_q <= maj;
      end
    end
  end

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bits_q, bits_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 push;
  logic                 half, mid;
  ent_t                 ent_new;

  assign half = tick && (cnt_q == CW'(OVERSAMPLE/2 - 1));
  assign mid  = tick && (cnt_q == CW'(OVERSAMPLE - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    shift_d = shift_q;
    par_d   = par_q;
    push    = 1'b0;
    if (tick) cnt_d = cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        bits_d = '0;
        if (!line_f_q) state_d = S_START;
      end
      S_START: if (half) begin
        cnt_d   = '0;
        state_d = line_f_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (mid) begin
        shift_d = {line_f_q, shift_q[DATA_BITS-1:1]};
        bits_d  = bits_q + 1'b1;
        if (bits_q == BW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: if (mid) begin
        par_d   = line_f_q;
        state_d = S_STOP;
      end
      S_STOP: if (mid) begin
        push    = 1'b1;
        state_d = line_f_q ? S_IDLE : S_BRKWAIT;
      end
      S_BRKWAIT: begin
        cnt_d = '0;
        if (line_f_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  // Flags are evaluated while the stop bit is being sampled and stored with the word
  always_comb begin
    ent_new.data = shift_q;
    ent_new.pe   = (PARITY != 0) && (par_q != ((^shift_q) ^ (PARITY == 2)));
    ent_new.fe   = !line_f_q;
    ent_new.bk   = !line_f_q && (shift_q == '0) && !par_q;
  end

  assign rx_busy_o = (state_q != S_IDLE);

  logic ovr_q, ovr_d;
  logic pop;
  ent_t head;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  ent_t          mem_q [FIFO_DEPTH];
  logic [AW:0]   wp_q, rp_q;
  logic          empty, full, wr;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop   = !empty && rx_o.rx_ready;
  assign wr    = push && (!full || pop);
  assign ovr_d = push && full && !pop;
  assign head  = empty ? '0 : mem_q[rp_q[AW-1:0]];
  assign rx_o.rx_valid = !empty;

  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q[AW-1:0]] <= ent_new;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (wr)  wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
    end
  end
`else
  ent_t hold_q;
  logic vld_q;

  assign pop   = vld_q && rx_o.rx_ready;
  assign ovr_d = push && vld_q && !pop;
  assign head  = hold_q;
  assign rx_o.rx_valid = vld_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
      vld_q  <= 1'b0;
    end else if (push && (!vld_q || pop)) begin
      hold_q <= ent_new;
      vld_q  <= 1'b1;
    end else if (pop) begin
      vld_q  <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) ovr_q <= 1'b0;
    else        ovr_q <= ovr_d;
  end

  assign rx_o.rx_data    = head.data;
  assign rx_o.parity_err = head.pe;
  assign rx_o.frame_err  = head.fe;
  assign rx_o.brk        = head.bk;
  assign rx_o.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench: three receivers (no/even/odd parity) fed random frames,
// compared against a frame-level model of expected words and flags.
module tb_uart_rx_frame;
  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int OS       = 16;
  localparam int BIT      = CLK_FREQ / BAUD;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct packed { logic [7:0] d; logic pe; logic fe; logic bk; } w_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rxd = 3'b111;
  logic [2:0] busy;
  int cyc = 0, vec = 0, err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_frame_if #(.DATA_BITS(8)) if0 ();
  uart_rx_frame_if #(.DATA_BITS(8)) if1 ();
  uart_rx_frame_if #(.DATA_BITS(8)) if2 ();

  uart_rx_frame #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                  .PARITY(0), .FIFO_DEPTH(4))
    u0 (.clk(clk), .rst_n(rst_n), .rxd_i(rxd[0]), .rx_busy_o(busy[0]), .rx_o(if0));
  uart_rx_frame #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                  .PARITY(1), .FIFO_DEPTH(4))
    u1 (.clk(clk), .rst_n(rst_n), .rxd_i(rxd[1]), .rx_busy_o(busy[1]), .rx_o(if1));
  uart_rx_frame #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                  .PARITY(2), .FIFO_DEPTH(4))
    u2 (.clk(clk), .rst_n(rst_n), .rxd_i(rxd[2]), .rx_busy_o(busy[2]), .rx_o(if2));

  w_t got0[$], got1[$], got2[$];
  int ovr0 = 0, vhi0 = 0, vcyc0 = -1, busyhi0 = 0, tstart = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (if0.rx_valid && if0.rx_ready) got0.push_back({if0.rx_data, if0.parity_err, if0.frame_err, if0.brk});
      if (if1.rx_valid && if1.rx_ready) got1.push_back({if1.rx_data, if1.parity_err, if1.frame_err, if1.brk});
      if (if2.rx_valid && if2.rx_ready) got2.push_back({if2.rx_data, if2.parity_err, if2.frame_err, if2.brk});
      if (if0.rx_valid) vhi0++;
      if (if0.rx_valid && vcyc0 < 0) vcyc0 = cyc;
      if (if0.overrun) ovr0++;
      if (busy[0]) busyhi0++;
    end
  end

  // Word the receiver must report for a frame, from the line-level description
  function automatic w_t model(input logic [7:0] d, input int pm, input logic pbit, input logic sbit);
    w_t w;
    int ones;
    ones = $countones(d) + ((pm != 0) ? int'(pbit) : 0);
    w.d  = d;
    w.pe = (pm != 0) && ((ones % 2) != ((pm == 2) ? 1 : 0));
    w.fe = !sbit;
    w.bk = !sbit && (d == 8'h00) && (pm == 0 || !pbit);
    return w;
  endfunction

  task automatic drive_bit(input int idx, input logic v);
    rxd[idx] = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input int idx, input logic [7:0] d, input int pm,
                            input logic pbit, input logic sbit, input int idle);
    if (idx == 0) tstart = cyc;
    drive_bit(idx, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(idx, d[i]);
    if (pm != 0) drive_bit(idx, pbit);
    drive_bit(idx, sbit);
    rxd[idx] = 1'b1;
    repeat (idle * BIT) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    vec++;
    if ({if0.rx_valid, if0.rx_data, if0.parity_err, if0.frame_err, if0.brk, if0.overrun, busy[0]} !== '0) begin
      err++; $display("FAIL reset_u0: got %b want 0", {if0.rx_valid, if0.rx_data, if0.parity_err, if0.frame_err, if0.brk, if0.overrun, busy[0]});
    end
    vec++;
    if ({if1.rx_valid, if1.rx_data, if1.parity_err, if1.overrun, busy[1]} !== '0) begin
      err++; $display("FAIL reset_u1: got %b want 0", {if1.rx_valid, if1.rx_data, if1.parity_err, if1.overrun, busy[1]});
    end
    vec++;
    if ({if2.rx_valid, if2.rx_data, if2.parity_err, if2.overrun, busy[2]} !== '0) begin
      err++; $display("FAIL reset_u2: got %b want 0", {if2.rx_valid, if2.rx_data, if2.parity_err, if2.overrun, busy[2]});
    end
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic test_basic;
    w_t exp_w, g;
    int lat;
    if0.rx_ready = 1'b1;
    vhi0 = 0; vcyc0 = -1; got0.delete();
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 2);
    exp_w = model(8'hA5, 0, 1'b0, 1'b1);
    vec++;
    if (got0.size() != 1) begin
      err++; $display("FAIL basic_count: got %0d words want 1", got0.size());
    end else begin
      g = got0.pop_front();
      vec++;
      if (g !== exp_w) begin err++; $display("FAIL basic_word: got %h want %h", g, exp_w); end
    end
    vec++;
    if (vhi0 != 1) begin err++; $display("FAIL basic_valid_width: got %0d clk want 1", vhi0); end
    lat = vcyc0 - tstart;
    vec++;
    if (lat < 9 * BIT + BIT / 2 - 2 || lat > 9 * BIT + BIT / 2 + 13) begin
      err++; $display("FAIL basic_latency: got %0d clk want about %0d", lat, 9 * BIT + BIT / 2 + 1);
    end
  endtask

  task automatic test_parity;
    w_t e1, e2, g;
    logic [7:0] d;
    logic pb;
    if1.rx_ready = 1'b1; if2.rx_ready = 1'b1;
    got1.delete(); got2.delete();
    for (int n = 0; n < 7; n++) begin
      d  = (n == 0) ? 8'h07 : 8'($urandom_range(0, 255));
      pb = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      fork
        send_frame(1, d, 1, pb, 1'b1, 1);
        send_frame(2, d, 2, pb, 1'b1, 1);
      join
      e1 = model(d, 1, pb, 1'b1);
      e2 = model(d, 2, pb, 1'b1);
      vec++;
      if (got1.size() != 1) begin err++; $display("FAIL parity_even_count: got %0d want 1", got1.size()); end
      else begin
        g = got1.pop_front();
        if (g !== e1) begin err++; $display("FAIL parity_even: got %h want %h", g, e1); end
      end
      vec++;
      if (got2.size() != 1) begin err++; $display("FAIL parity_odd_count: got %0d want 1", got2.size()); end
      else begin
        g = got2.pop_front();
        if (g !== e2) begin err++; $display("FAIL parity_odd: got %h want %h", g, e2); end
      end
      got1.delete(); got2.delete();
    end
  endtask

  task automatic test_frame_err;
    w_t e, g;
    got0.delete();
    send_frame(0, 8'h3C, 0, 1'b0, 1'b0, 2);
    send_frame(0, 8'h11, 0, 1'b0, 1'b1, 2);
    for (int i = 0; i < 2; i++) begin
      e = (i == 0) ? model(8'h3C, 0, 1'b0, 1'b0) : model(8'h11, 0, 1'b0, 1'b1);
      vec++;
      if (got0.size() == 0) begin err++; $display("FAIL frame_err_word%0d: got none want %h", i, e); end
      else begin
        g = got0.pop_front();
        if (g !== e) begin err++; $display("FAIL frame_err_word%0d: got %h want %h", i, g, e); end
      end
    end
  endtask

  task automatic test_break;
    w_t g, e;
    got0.delete();
    rxd[0] = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    vec++;
    if (got0.size() != 1) begin err++; $display("FAIL break_count: got %0d want 1", got0.size()); end
    else begin
      g = got0.pop_front();
      e = model(8'h00, 0, 1'b0, 1'b0);
      vec++;
      if (g !== e) begin err++; $display("FAIL break_word: got %h want %h", g, e); end
    end
    send_frame(0, 8'h5A, 0, 1'b0, 1'b1, 2);
    vec++;
    if (got0.size() != 1 || got0[0] !== model(8'h5A, 0, 1'b0, 1'b1)) begin
      err++; $display("FAIL break_recover: got %0d words want one 5a", got0.size());
    end
    got0.delete();
  endtask

  task automatic test_glitch;
    got0.delete();
    busyhi0 = 0;
    rxd[0] = 1'b0;
    repeat (3) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (BIT + 4) @(negedge clk);
    vec++;
    if (busy[0] !== 1'b0) begin err++; $display("FAIL glitch_busy: got %b want 0", busy[0]); end
    vec++;
    if (busyhi0 == 0) begin err++; $display("FAIL glitch_start: got busy never high want start seen"); end
    repeat (10 * BIT) @(negedge clk);
    vec++;
    if (got0.size() != 0) begin err++; $display("FAIL glitch_word: got %0d words want 0", got0.size()); end
  endtask

  task automatic test_back_to_back;
    w_t exp_q[$];
    w_t g;
    logic [7:0] d;
    logic sb;
    int o;
    got0.delete();
    o = ovr0;
    for (int n = 0; n < 10; n++) begin
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      exp_q.push_back(model(d, 0, 1'b0, sb));
      send_frame(0, d, 0, 1'b0, sb, sb ? 0 : 1);
    end
    repeat (2 * BIT) @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      vec++;
      if (got0.size() == 0) begin err++; $display("FAIL b2b_word%0d: got none want %h", n, exp_q[n]); end
      else begin
        g = got0.pop_front();
        if (g !== exp_q[n]) begin err++; $display("FAIL b2b_word%0d: got %h want %h", n, g, exp_q[n]); end
      end
    end
    vec++;
    if (ovr0 != o) begin err++; $display("FAIL b2b_overrun: got %0d pulses want 0", ovr0 - o); end
  endtask

  task automatic test_overrun;
    w_t exp_q[$];
    w_t g;
    logic [7:0] d;
    int o;
    got0.delete();
    if0.rx_ready = 1'b0;
    o = ovr0;
    for (int n = 0; n <= DEPTH; n++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(model(d, 0, 1'b0, 1'b1));
      send_frame(0, d, 0, 1'b0, 1'b1, 1);
    end
    vec++;
    if (ovr0 - o != 1) begin err++; $display("FAIL overrun_pulses: got %0d want 1", ovr0 - o); end
    vec++;
    if (if0.rx_valid !== 1'b1 || if0.rx_data !== exp_q[0].d) begin
      err++; $display("FAIL overrun_head: got v=%b d=%h want v=1 d=%h", if0.rx_valid, if0.rx_data, exp_q[0].d);
    end
    if0.rx_ready = 1'b1;
    repeat (DEPTH + 4) @(negedge clk);
    vec++;
    if (got0.size() != DEPTH) begin err++; $display("FAIL overrun_held: got %0d words want %0d", got0.size(), DEPTH); end
    for (int n = 0; n < DEPTH; n++) begin
      vec++;
      if (got0.size() == 0) begin err++; $display("FAIL overrun_order%0d: got none want %h", n, exp_q[n]); end
      else begin
        g = got0.pop_front();
        if (g !== exp_q[n]) begin err++; $display("FAIL overrun_order%0d: got %h want %h", n, g, exp_q[n]); end
      end
    end
  endtask

  task automatic test_reset_mid;
    if0.rx_ready = 1'b0;
    send_frame(0, 8'h6B, 0, 1'b0, 1'b1, 1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vec++;
    if ({if0.rx_valid, if0.rx_data, if0.frame_err, if0.overrun, busy[0]} !== '0) begin
      err++; $display("FAIL reset_mid: got %b want 0", {if0.rx_valid, if0.rx_data, if0.frame_err, if0.overrun, busy[0]});
    end
    rxd[0] = 1'b1;
    rst_n = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    got0.delete();
    if0.rx_ready = 1'b1;
    send_frame(0, 8'hC3, 0, 1'b0, 1'b1, 2);
    vec++;
    if (got0.size() != 1 || got0[0] !== model(8'hC3, 0, 1'b0, 1'b1)) begin
      err++; $display("FAIL reset_recover: got %0d words want one c3", got0.size());
    end
  endtask

  initial begin
    if0.rx_ready = 1'b1;
    if1.rx_ready = 1'b1;
    if2.rx_ready = 1'b1;
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_break();
    test_glitch();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised RS-232 receiver that replaces the fixed 8N1 receiver in the host-link path. It supports a configurable data width, parity mode and oversampling rate, and reports line errors. It delivers each received word through a valid/ready handshake instead of a bare strobe. It sits between the board RXD pin and the command decoder, with optional output buffering.

## Interface
Parameters:
- CLK_FREQ, 50000000: clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- OVERSAMPLE, 16: ticks per bit; power of 2, ≥8. CLK_FREQ ≥ BAUD*OVERSAMPLE.
- DATA_BITS, 8: word width, 5..9, sent LSB first.
- PARITY, 0: 0 none, 1 even, 2 odd.
- FIFO_DEPTH, 4: power of 2, ≥2. Used only with UART_RX_FIFO_EN.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  synchronous reset, active-low.
- rxd  in  1  asynchronous serial line, idle high.
- rx_data  out  DATA_BITS  received word (head of buffer).
- rx_valid  out  1  rx_data and its flags are valid.
- rx_ready  in  1  consumer accepts the word when rx_valid & rx_ready.
- parity_err  out  1  parity mismatch on the presented word; 0 when PARITY=0.
- frame_err  out  1  stop bit sampled low on the presented word.
- brk  out  1  break: all data, parity and stop samples low.
- overrun  out  1  one-cycle pulse: a completed word was dropped.
- rx_busy  out  1  frame reception in progress (state ≠ IDLE).

## Operation
- rxd passes through a 2-flop synchroniser on clk (reset value 1). A 3-sample majority filter on the oversample tick produces line_f (reset value 1).
- Tick generator: fractional phase accumulator, free-running from reset, emits a 1-clk tick at BAUD*OVERSAMPLE. Accumulated error is within ±1% over a frame.
- FSM states:
  - IDLE: line_f = 0 → START; tick counter cleared.
  - START: after OVERSAMPLE/2 ticks, line_f = 1 → IDLE (glitch rejected); otherwise → DATA.
  - DATA: sample every OVERSAMPLE ticks into a shift register, LSB first. After DATA_BITS samples → PARITY if PARITY≠0, else STOP.
  - PARITY: sample, then compare against the XOR of the data; odd mode inverts the expected value. → STOP.
  - STOP: sample and complete the word (push). Sample 1 → IDLE. Sample 0 → BRKWAIT.
  - BRKWAIT: line_f = 1 → IDLE. No start detection while in this state.
- Flags are computed at push time and stored with the word. brk implies frame_err.
- Without buffer: a single holding register. Pop on rx_valid & rx_ready. A push while the register is full and not popping in the same cycle drops the new word and pulses overrun; the held word is unchanged.

## Timing
- Reset values: rx_valid 0, rx_data 0, all flags 0, overrun 0, rx_busy 0, FSM IDLE, buffer empty, accumulator 0.
- rx_valid rises on the clk after the tick that samples the stop bit.
- Push and pop in the same cycle: the pop completes and the new word is stored; no overrun, even when full.
- rx_data and the flags are stable while rx_valid & !rx_ready.
- rst_n low mid-frame: the partial word is discarded, the buffer is emptied, and reset values apply on the next edge.
- rx_busy rises 1 clk after line_f falls in IDLE. It falls on the clk the FSM re-enters IDLE.

## Configuration
- UART_RX_FIFO_EN defined: the holding register is replaced by a FIFO_DEPTH-entry FIFO of {data, parity_err, frame_err, brk}.
  - Read and write pointers wrap modulo FIFO_DEPTH; there is an extra bit for full/empty.
  - rx_valid = !empty. rx_data and flags are combinational from the head entry.
  - Push when full without a same-cycle pop: the word is dropped and overrun pulses.
- UART_RX_FIFO_EN undefined: single holding register as described in Operation. FIFO_DEPTH is ignored.

## Test plan
Bench parameters: CLK_FREQ=1600000, BAUD=100000, OVERSAMPLE=16 (one tick per clk, 16 clk/bit).
- 8N1, send 0xA5 with rx_ready=1 → rx_valid high for 1 clk with rx_data=0xA5, all flags 0. rx_valid rises 1 clk after the stop-bit midpoint.
- PARITY=1, send 0x07 with parity bit 0 → rx_data=0x07, parity_err=1. PARITY=2 with the same frame → parity_err=0.
- Send 0x3C with stop bit driven low, then line high → frame_err=1, brk=0, rx_data=0x3C. The next frame 0x11 is received cleanly.
- Hold rxd low for 20 bit times, then high → exactly one word 0x00 with brk=1 and frame_err=1. The next start is detected only after the line returns high.
- Drive a 3-clk low glitch while idle → no word produced; rx_busy returns to 0 by the START midpoint.
- Overrun with rx_ready=0:
  - Macro undefined: send 0x12 then 0x34 → rx_data stays 0x12 and overrun pulses once.
  - Macro defined, FIFO_DEPTH=4: send five words → four are held in order and overrun pulses on the fifth. Reset mid-frame → rx_valid=0.
